// File: rtl/sdpram_fifo_ctrl_pkg.sv
// Shared helpers for the SDPRAM stream FIFO controller: width derivation
// for counters and ring-buffer indices.
package sdpram_fifo_ctrl_pkg;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdpram_if.sv
// Simple dual-port RAM bundle: port A writes, port B issues reads whose
// data returns with dvalb after the RAM's fixed read latency.
interface sdpram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int BYTE_WRITE = 0
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int STRB_WIDTH = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1;

    logic [ADDR_WIDTH-1:0] addra;
    logic [STRB_WIDTH-1:0] wena;
    logic [DATA_WIDTH-1:0] dina;
    logic [ADDR_WIDTH-1:0] addrb;
    logic                  renb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  dvalb;

    modport sdp_m (output addra, wena, dina, addrb, renb, input doutb, dvalb);
    modport sdp_s (input addra, wena, dina, addrb, renb, output doutb, dvalb);
endinterface

// File: rtl/sdpram_fifo_ctrl_prefetch_buf.sv
// Small register FIFO holding words returned by the RAM until the consumer
// takes them; push and pop may happen in the same cycle.
module sdpram_prefetch_buf
    import sdpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CW        = cnt_width(DEPTH),
    localparam int IW        = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CW-1:0]         cnt_o
);
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_push  = push_i && (cnt_q != CW'(DEPTH));
        do_pop   = pop_i && (cnt_q != '0);
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (do_push) begin
            wr_idx_d = (wr_idx_q == IW'(DEPTH - 1)) ? '0 : wr_idx_q + IW'(1);
        end
        if (do_pop) begin
            rd_idx_d = (rd_idx_q == IW'(DEPTH - 1)) ? '0 : rd_idx_q + IW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                data_q[wr_idx_q] <= din_i;
            end
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o = data_q[rd_idx_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// Stream FIFO controller on the master side of a simple dual-port RAM:
// writes the input stream into the RAM and prefetches it back in order.
module sdpram_fifo_ctrl
    import sdpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int BYTE_WRITE     = 0,
    parameter int PREFETCH_DEPTH = 4,
    localparam int ADDR_WIDTH    = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH    = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1,
    localparam int CNT_WIDTH     = cnt_width(MEM_DEPTH + PREFETCH_DEPTH),
    localparam int PF_WIDTH      = cnt_width(PREFETCH_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  err,
    sdpram_if.sdp_m               mem
);
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic [PF_WIDTH-1:0]   inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [PF_WIDTH-1:0]   buf_cnt, buf_cnt_nxt;
    logic [PF_WIDTH:0]     credit;
    logic                  push, renb, bpush, pop;

    always_comb begin
        s_ready = !rst && (mem_cnt_q != (ADDR_WIDTH + 1)'(MEM_DEPTH));
        push    = s_valid && s_ready;
        // Words in flight plus words buffered may never exceed the buffer,
        // so returning data always has a free slot.
        credit  = {1'b0, inflight_q} + {1'b0, buf_cnt};
        renb    = !rst && (mem_cnt_q != '0) && (credit < (PF_WIDTH + 1)'(PREFETCH_DEPTH));
        bpush   = mem.dvalb && (inflight_q != '0);
        m_valid = (buf_cnt != '0);
        pop     = m_valid && m_ready;

        wr_ptr_d    = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d    = renb ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        mem_cnt_d   = mem_cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(renb);
        inflight_d  = inflight_q + PF_WIDTH'(renb) - PF_WIDTH'(bpush);
        buf_cnt_nxt = buf_cnt + PF_WIDTH'(bpush) - PF_WIDTH'(pop);
        err_d       = err_q || (mem.dvalb && (inflight_q == '0));
        count_d     = CNT_WIDTH'(mem_cnt_d) + CNT_WIDTH'(inflight_d) + CNT_WIDTH'(buf_cnt_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    sdpram_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PREFETCH_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (bpush),
        .din_i  (mem.doutb),
        .pop_i  (pop),
        .head_o (m_data),
        .cnt_o  (buf_cnt)
    );

    assign mem.wena  = {STRB_WIDTH{push}};
    assign mem.addra = wr_ptr_q;
    assign mem.dina  = s_data;
    assign mem.renb  = renb;
    assign mem.addrb = rd_ptr_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed bench for sdpram_fifo_ctrl with a behavioural SDPRAM of
// selectable read latency (1..3) and a stray-dvalb injector.
module tb_sdpram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready, err;
    logic [31:0] s_data, m_data;
    logic [10:0] count;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    logic [31:0] exp_q [$];

    logic [1:0]  lat_sel;
    logic        inj_v;
    logic [31:0] inj_d;
    logic [31:0] ram [1024];
    logic [2:0]  pv;
    logic [31:0] pd [3];

    sdpram_if #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .BYTE_WRITE(0)) mem_if ();

    sdpram_fifo_ctrl #(
        .DATA_WIDTH(32), .MEM_DEPTH(1024), .BYTE_WRITE(0), .PREFETCH_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .err(err), .mem(mem_if)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: read data appears with dvalb lat_sel+1 cycles after renb.
    always @(posedge clk) begin
        if (mem_if.wena[0]) ram[mem_if.addra] <= mem_if.dina;
        if (rst) pv <= '0;
        else     pv <= {pv[1:0], mem_if.renb};
        pd[0] <= ram[mem_if.addrb];
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end
    assign mem_if.dvalb = pv[lat_sel] | inj_v;
    assign mem_if.doutb = inj_v ? inj_d : pd[lat_sel];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle with scoreboard tracking: count, credit bound and popped data.
    task automatic run_cycle(output logic acc);
        logic pp;
        logic [31:0] exp_v;
        @(negedge clk);
        chk("count_model", count, exp_q.size());
        chk("credit_bound", (int'(dut.inflight_q) + int'(dut.buf_cnt)) <= 4, 1);
        acc = s_valid && s_ready;
        pp  = m_valid && m_ready;
        if (pp) begin
            rx_cnt++;
            if (exp_q.size() == 0) chk("unexpected_pop", m_valid, 0);
            else begin
                exp_v = exp_q.pop_front();
                chk("m_data", m_data, exp_v);
            end
        end
        if (acc) exp_q.push_back(s_data);
        cyc();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int sent;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        lat_sel = 2'd0; inj_v = 1'b0; inj_d = '0;

        // 1: reset held two cycles
        cyc();
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_wena", mem_if.wena, 0);
        chk("rst_renb", mem_if.renb, 0);
        chk("rst_count", count, 0);
        cyc();
        @(negedge clk);
        chk("rst2_s_ready", s_ready, 0);
        rst = 1'b0;
        #1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_count", count, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_renb", mem_if.renb, 0);
        cyc();

        // 2: single word, L=1
        s_valid = 1'b1; s_data = 32'hDEADBEEF; m_ready = 1'b1;
        @(negedge clk);
        chk("t0_wena", mem_if.wena, 1);
        chk("t0_addra", mem_if.addra, 0);
        chk("t0_dina", mem_if.dina, 32'hDEADBEEF);
        cyc();
        s_valid = 1'b0;
        @(negedge clk);
        chk("t1_renb", mem_if.renb, 1);
        chk("t1_addrb", mem_if.addrb, 0);
        chk("t1_count", count, 1);
        chk("t1_m_valid", m_valid, 0);
        cyc();
        @(negedge clk);
        chk("t2_dvalb", mem_if.dvalb, 1);
        chk("t2_m_valid", m_valid, 0);
        cyc();
        @(negedge clk);
        chk("t3_m_valid", m_valid, 1);
        chk("t3_m_data", m_data, 32'hDEADBEEF);
        cyc();
        @(negedge clk);
        chk("t4_m_valid", m_valid, 0);
        chk("t4_count", count, 0);
        cyc();
        m_ready = 1'b0;

        // 3: fill to capacity, pop one, drain across the wrap
        for (int i = 0; i < 1028; i++) begin
            s_valid = 1'b1; s_data = i;
            run_cycle(a);
            chk("fill_accept", a, 1);
        end
        s_data = 32'hFFFF;
        @(negedge clk);
        chk("full_s_ready", s_ready, 0);
        chk("full_wena", mem_if.wena, 0);
        chk("full_count", count, 1028);
        chk("full_inflight", dut.inflight_q, 0);
        chk("full_m_data", m_data, 0);
        cyc();
        s_valid = 1'b0; m_ready = 1'b1;
        run_cycle(a);
        m_ready = 1'b0;
        @(negedge clk);
        chk("pop1_s_ready", s_ready, 0);
        chk("pop1_renb", mem_if.renb, 1);
        cyc();
        @(negedge clk);
        chk("pop2_s_ready", s_ready, 1);
        chk("pop2_count", count, 1027);
        cyc();
        m_ready = 1'b1;
        for (int c = 0; c < 5000 && exp_q.size() > 0; c++) run_cycle(a);
        chk("drain_left", exp_q.size(), 0);
        @(negedge clk);
        chk("drain_count", count, 0);
        chk("drain_m_valid", m_valid, 0);
        cyc();

        // 4: random stream, L=3
        lat_sel = 2'd2;
        rx_cnt = 0; sent = 0;
        for (int c = 0; c < 40000 && (sent < 10000 || exp_q.size() > 0); c++) begin
            s_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 3) != 0);
            run_cycle(a);
            if (a) sent++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        chk("stream_rx", rx_cnt, 10000);
        @(negedge clk);
        chk("stream_count", count, 0);
        cyc();

        // 5: stray dvalb
        inj_v = 1'b1; inj_d = 32'h1234;
        cyc();
        inj_v = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1);
        chk("stray_m_valid", m_valid, 0);
        chk("stray_count", count, 0);
        cyc();
        s_valid = 1'b1; s_data = 32'h77;
        run_cycle(a);
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) run_cycle(a);
        chk("stray_left", exp_q.size(), 0);
        @(negedge clk);
        chk("stray_err_sticky", err, 1);
        cyc();
        m_ready = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("stray_err_cleared", err, 0);
        cyc();

        // 6: reset with 10 words held
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 100 + i;
            run_cycle(a);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle(a);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_rd_ptr", dut.rd_ptr_q, 0);
        chk("mid_rst_wr_ptr", dut.wr_ptr_q, 0);
        cyc();
        s_valid = 1'b1; s_data = 32'hA5;
        @(negedge clk);
        chk("a5_addra", mem_if.addra, 0);
        chk("a5_wena", mem_if.wena, 1);
        cyc();
        s_valid = 1'b0;
        @(negedge clk);
        chk("a5_renb", mem_if.renb, 1);
        chk("a5_addrb", mem_if.addrb, 0);
        cyc();
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid) break;
            cyc();
        end
        chk("a5_m_valid", m_valid, 1);
        chk("a5_m_data", m_data, 32'hA5);
        chk("a5_err", err, 0);
        cyc();
        m_ready = 1'b0;
        @(negedge clk);
        chk("a5_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
